// File: rtl/spi_pkg.sv
// ---------------------------------------------------------------------------
// spi_pkg
// Shared definitions for the serial receive/transmit blocks. It holds the
// receiver FSM state type and the default word length and synchroniser depth,
// so that the SIPO receiver and any PISO-side blocks agree on them.
// ---------------------------------------------------------------------------
package spi_pkg;

    // Default serial word length in bits.
    localparam int SPI_WIDTH       = 9;

    // Default number of flops in each input synchroniser chain.
    localparam int SPI_SYNC_STAGES = 2;

    // Receiver framing states.
    typedef enum logic {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } spi_state_t;

endpackage : spi_pkg

// File: rtl/sync_ff.sv
// ---------------------------------------------------------------------------
// sync_ff
// Multi-flop synchroniser that brings a single asynchronous signal into the
// clk domain. The chain resets to RESET_VAL so that an inactive-high input,
// such as a chip select, does not look active while the chain is filling.
//
// Ports
//   clk     : destination clock
//   reset_n : asynchronous active-low reset
//   d       : asynchronous input
//   q       : synchronised output, DEPTH clk cycles behind d
// ---------------------------------------------------------------------------
module sync_ff #(
    parameter int   DEPTH     = 2,
    parameter logic RESET_VAL = 1'b0
) (
    input  logic clk,
    input  logic reset_n,
    input  logic d,
    output logic q
);

    logic [DEPTH-1:0] chain;

    // A depth of one has no bits to shift along, so it is a plain flop.
    generate
        if (DEPTH == 1) begin : g_single
            always_ff @(posedge clk or negedge reset_n) begin
                if (!reset_n) begin
                    chain <= RESET_VAL;
                end else begin
                    chain <= d;
                end
            end
        end else begin : g_chain
            always_ff @(posedge clk or negedge reset_n) begin
                if (!reset_n) begin
                    chain <= {DEPTH{RESET_VAL}};
                end else begin
                    chain <= {chain[DEPTH-2:0], d};
                end
            end
        end
    endgenerate

    assign q = chain[DEPTH-1];

endmodule : sync_ff

// File: rtl/sipo_rx.sv
// ---------------------------------------------------------------------------
// sipo_rx
// Serial-in, parallel-out receiver. An externally clocked serial stream
// (sclk_in / sdi / cs_n) is synchronised into the clk domain. While cs_n is
// low, bits are shifted in LSB first on each rising edge of sclk_in, and each
// completed word is placed in a single holding register with a valid/ready
// handshake. Words that arrive while the holding register is still full are
// dropped and flagged by a sticky overrun bit. A frame that ends part-way
// through a word raises a one-cycle frame_err pulse.
// WIDTH must be at least 2. sclk_in high and low phases must each last at
// least two clk periods.
//
// Ports
//   clk       : system clock; all state changes on its rising edge
//   reset_n   : asynchronous active-low reset
//   sclk_in   : external serial clock, asynchronous to clk
//   sdi       : serial data, LSB first, sampled on sclk_in rising edge
//   cs_n      : active-low frame enable, high when idle
//   rx_data   : received word holding register
//   rx_valid  : rx_data holds a word that has not been consumed
//   rx_ready  : consumer takes rx_data when rx_valid and rx_ready are both high
//   overrun   : sticky; a completed word was dropped
//   frame_err : one-cycle pulse; a frame ended mid-word
// ---------------------------------------------------------------------------
module sipo_rx
    import spi_pkg::*;
#(
    parameter int WIDTH       = SPI_WIDTH,
    parameter int SYNC_STAGES = SPI_SYNC_STAGES
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             sclk_in,
    input  logic             sdi,
    input  logic             cs_n,
    output logic [WIDTH-1:0] rx_data,
    output logic             rx_valid,
    input  logic             rx_ready,
    output logic             overrun,
    output logic             frame_err
);

    localparam int               CNT_W    = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(WIDTH - 1);

    logic             sclk_s;
    logic             sdi_s;
    logic             cs_n_s;
    logic             sclk_prev;
    logic             sclk_rise;
    spi_state_t       state;
    logic [CNT_W-1:0] bit_cnt;
    logic [WIDTH-1:0] shreg;
    logic             word_done;

    // Chip select idles high, so its chain resets high to avoid a false frame
    // start straight out of reset.
    sync_ff #(.DEPTH(SYNC_STAGES), .RESET_VAL(1'b0)) u_sync_sclk (
        .clk     (clk),
        .reset_n (reset_n),
        .d       (sclk_in),
        .q       (sclk_s)
    );

    sync_ff #(.DEPTH(SYNC_STAGES), .RESET_VAL(1'b0)) u_sync_sdi (
        .clk     (clk),
        .reset_n (reset_n),
        .d       (sdi),
        .q       (sdi_s)
    );

    sync_ff #(.DEPTH(SYNC_STAGES), .RESET_VAL(1'b1)) u_sync_cs (
        .clk     (clk),
        .reset_n (reset_n),
        .d       (cs_n),
        .q       (cs_n_s)
    );

    // One-cycle pulse on each synchronised rising edge of the serial clock.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sclk_prev <= 1'b0;
        end else begin
            sclk_prev <= sclk_s;
        end
    end

    assign sclk_rise = sclk_s & ~sclk_prev;

    // Framing FSM and shifter. word_done is a registered strobe marking that
    // shreg now holds a complete word; because sclk_in phases last at least
    // two clk periods, shreg cannot shift again before the holding register
    // logic has taken the word on the following edge. When cs_n rises, a
    // nonzero bit count means a partial word is being abandoned.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state     <= IDLE;
            bit_cnt   <= '0;
            shreg     <= '0;
            word_done <= 1'b0;
            frame_err <= 1'b0;
        end else begin
            word_done <= 1'b0;
            frame_err <= 1'b0;
            case (state)
                IDLE: begin
                    if (!cs_n_s) begin
                        state   <= SHIFT;
                        bit_cnt <= '0;
                    end
                end
                SHIFT: begin
                    if (cs_n_s) begin
                        state   <= IDLE;
                        bit_cnt <= '0;
                        if (bit_cnt != '0) begin
                            frame_err <= 1'b1;
                        end
                    end else if (sclk_rise) begin
                        shreg <= {sdi_s, shreg[WIDTH-1:1]};
                        if (bit_cnt == LAST_BIT) begin
                            bit_cnt   <= '0;
                            word_done <= 1'b1;
                        end else begin
                            bit_cnt <= bit_cnt + 1'b1;
                        end
                    end
                end
                default: begin
                    state   <= IDLE;
                    bit_cnt <= '0;
                end
            endcase
        end
    end

    // Holding register with valid/ready handshake. A completed word is taken
    // when the register is empty or is being consumed on the same edge;
    // otherwise it is dropped and overrun is latched. overrun clears on the
    // next handshake; a handshake implies rx_ready, so a new overrun can never
    // coincide with the clear.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            rx_data  <= '0;
            rx_valid <= 1'b0;
            overrun  <= 1'b0;
        end else begin
            if (word_done && (!rx_valid || rx_ready)) begin
                rx_data  <= shreg;
                rx_valid <= 1'b1;
            end else if (rx_valid && rx_ready) begin
                rx_valid <= 1'b0;
            end

            if (word_done && rx_valid && !rx_ready) begin
                overrun <= 1'b1;
            end else if (rx_valid && rx_ready) begin
                overrun <= 1'b0;
            end
        end
    end

endmodule : sipo_rx

// File: doc/sipo_rx.md
SIPO_RX -- requirements
Module: sipo_rx

Interface
REQ-001 Parameter WIDTH, default 9: serial word length in bits.
REQ-002 Parameter SYNC_STAGES, default 2: synchroniser depth on the sclk_in, sdi and cs_n inputs.
REQ-003 Port clk, input, 1: sole system clock; all state updates on its rising edge.
REQ-004 Port reset_n, input, 1: asynchronous, active-low reset.
REQ-005 Port sclk_in, input, 1: external serial clock, asynchronous to clk; data is sampled on its rising edge.
REQ-006 Port sdi, input, 1: serial data, LSB first.
REQ-007 Port cs_n, input, 1: active-low frame enable; high means idle.
REQ-008 Port rx_data, output, WIDTH: received word holding register.
REQ-009 Port rx_valid, output, 1: rx_data holds an unread word.
REQ-010 Port rx_ready, input, 1: consumer accepts rx_data when rx_valid and rx_ready are both high on a clk edge.
REQ-011 Port overrun, output, 1: sticky; a completed word was dropped.
REQ-012 Port frame_err, output, 1: one-cycle pulse; a frame was aborted mid-word.

Function
REQ-013 Each of sclk_in, sdi and cs_n SHALL pass through a SYNC_STAGES flop chain; only synchronised versions SHALL be used internally.
REQ-014 Rising-edge detect: sclk_rise = sclk_s & ~sclk_prev, with sclk_prev a register of sclk_s.
REQ-015 sclk_in high and low phases SHALL each be at least 2 clk periods; faster sclk_in is unsupported and unchecked.
REQ-016 FSM states: IDLE, SHIFT.
- IDLE -> SHIFT when synchronised cs_n is low; bit counter cleared.
- SHIFT -> IDLE when synchronised cs_n is high.
REQ-017 In SHIFT, on each sclk_rise: shift register <= {sdi_s, shreg[WIDTH-1:1]} (LSB first) and the bit counter increments.
REQ-018 On the sclk_rise that captures bit WIDTH-1:
- the complete word is produced and the counter wraps to 0;
- the FSM stays in SHIFT, so back-to-back words within one cs_n frame are received.
REQ-019 Word completion with the holding register empty, or being consumed in the same cycle:
- rx_data <= word and rx_valid <= 1 on the next clk edge.
- Latency: bit WIDTH-1 is detected at edge N; rx_valid is high from edge N+1.
REQ-020 Word completion while rx_valid=1 and rx_ready=0:
- the new word is dropped;
- rx_data is unchanged;
- overrun <= 1.
REQ-021 overrun SHALL clear on the first handshake (rx_valid & rx_ready) after it was set, unless a new overrun occurs in the same cycle, in which case it stays set.
REQ-022 Handshake with no word completing: rx_valid <= 0 on the next edge; rx_data holds its value.
REQ-023 cs_n rising in SHIFT with the bit counter nonzero:
- partial word discarded;
- frame_err pulses for exactly 1 cycle;
- rx_valid and rx_data unaffected.
REQ-024 cs_n rising with the counter at 0 SHALL NOT raise frame_err.
REQ-025 A sclk_rise in IDLE SHALL be ignored.
REQ-026 The bit counter width SHALL be $clog2(WIDTH); comparison is against WIDTH-1.

Reset
REQ-027 Reset values:
- synchronisers: sclk and sdi chains 0, cs_n chain 1;
- FSM IDLE, counter 0, shift register 0;
- rx_data 0, rx_valid 0, overrun 0, frame_err 0.
REQ-028 Reset asserted mid-word SHALL discard all partial and held data with no frame_err pulse; reception restarts only after cs_n is sampled low following reset release.

Structure
REQ-029 A shared package spi_pkg SHALL hold the FSM state enum, the default WIDTH (9) and the default SYNC_STAGES (2), for reuse by piso-side blocks.
REQ-030 The synchroniser SHALL be a sub-module sync_ff (parameterised depth, reset value) instantiated three times; everything else lives in sipo_rx.

Verification
REQ-031 Stimulus: cs_n low, send 9'h1A5 LSB first at clk/10, rx_ready=1. Response: rx_valid pulses once, rx_data=9'h1A5, overrun=0.
REQ-032 Stimulus: one frame carrying 9'h0FF then 9'h100 back-to-back, rx_ready held 0. Response: rx_data=9'h0FF, overrun=1 after the second word; first handshake returns 9'h0FF and clears overrun.
REQ-033 Stimulus: cs_n raised after 5 bits. Response: frame_err is a single 1-cycle pulse, rx_valid stays 0; the next full frame with 9'h055 is received correctly.
REQ-034 Stimulus: rx_ready asserted in the same cycle the second word completes. Response: no overrun; rx_data updates to the second word, rx_valid stays 1.
REQ-035 Stimulus: reset_n pulsed low after 4 bits. Response: all outputs 0 immediately; the next frame 9'h1C3 is received intact.
REQ-036 Stimulus: sclk_in toggled with cs_n high. Response: no rx_valid, no frame_err.
